btn_conditioner: RTL

- Conditions the raw push-button inputs before they reach the game logic's key input.
- Per button: two-flop synchroniser, counter-based debounce FSM, and a registered clean level for the game's key port.
- Also produces one-cycle press, release and auto-repeat "tick" pulses for step-wise paddle motion.
- Sits in the top level between the board button pins and the game block, on the pixel clock domain.

---
 rtl/btn_conditioner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button two-flop synchroniser, counter-based debounce
// FSM, registered clean level, and one-cycle press / release / auto-repeat
// tick pulses for step-wise paddle motion.
module btn_conditioner #(
  parameter int N_BTN         = 2,
  parameter int ACTIVE_LOW    = 0,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_tick
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             POL         = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] s;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign s = sync2_q ^ {N_BTN{POL}};

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    state_t           state_q, state_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] rpt_limit;
    logic             first_done_q, first_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             tick_q, tick_d;

    // First repeat waits the long delay, later ones use the short period.
    assign rpt_limit = first_done_q ? PERIOD_LAST : DELAY_LAST;

    // Debounce / auto-repeat next-state and pulse decode.
    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rpt_d        = rpt_q;
      first_done_d = first_done_q;
      level_d      = level_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      tick_d       = 1'b0;
      case (state_q)
        REL: begin
          if (s[gi]) begin
            state_d = REL_CHK;
            cnt_d   = '0;
          end
        end
        REL_CHK: begin
          if (!s[gi]) begin
            state_d = REL;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d      = PRS;
            cnt_d        = '0;
            level_d      = 1'b1;
            press_d      = 1'b1;
            tick_d       = 1'b1;
            rpt_d        = '0;
            first_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRS: begin
          if (!s[gi]) begin
            state_d = PRS_CHK;
            cnt_d   = '0;
          end else if (rpt_q == rpt_limit) begin
            tick_d       = 1'b1;
            rpt_d        = '0;
            first_done_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
        PRS_CHK: begin
          // Repeat counter is held here so a short release glitch only
          // delays the next tick instead of restarting the repeat cadence.
          if (s[gi]) begin
            state_d = PRS;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d      = REL;
            cnt_d        = '0;
            level_d      = 1'b0;
            release_d    = 1'b1;
            rpt_d        = '0;
            first_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q      <= REL;
        cnt_q        <= '0;
        rpt_q        <= '0;
        first_done_q <= 1'b0;
        level_q      <= 1'b0;
        press_q      <= 1'b0;
        release_q    <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        rpt_q        <= rpt_d;
        first_done_q <= first_done_d;
        level_q      <= level_d;
        press_q      <= press_d;
        release_q    <= release_d;
        tick_q       <= tick_d;
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_tick[gi]    = tick_q;
  end

endmodule
